// File: rtl/segment_scan_decoder.sv
// Decoder for a scanned two-digit seven-segment display.
// It watches the anode and cathode lines that drive a multiplexed display
// and recovers the hex digit shown on each position. A pattern counts as
// shown once it has held steady for SETTLE_CYCLES synchronized cycles.
module segment_scan_decoder #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       a0,
    input  logic       a1,
    input  logic [6:0] cathode,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic       valid0,
    output logic       valid1,
    output logic       frame_done,
    output logic       code_error,
    output logic       overlap_error
);

    localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Returns {hit, blank, hex} for an active-high abcdefg pattern.
    function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'h7E:   res = {2'b10, 4'h0};
            7'h30:   res = {2'b10, 4'h1};
            7'h6D:   res = {2'b10, 4'h2};
            7'h79:   res = {2'b10, 4'h3};
            7'h33:   res = {2'b10, 4'h4};
            7'h5B:   res = {2'b10, 4'h5};
            7'h5F:   res = {2'b10, 4'h6};
            7'h70:   res = {2'b10, 4'h7};
            7'h7F:   res = {2'b10, 4'h8};
            7'h7B:   res = {2'b10, 4'h9};
            7'h77:   res = {2'b10, 4'hA};
            7'h1F:   res = {2'b10, 4'hB};
            7'h4E:   res = {2'b10, 4'hC};
            7'h3D:   res = {2'b10, 4'hD};
            7'h4F:   res = {2'b10, 4'hE};
            7'h47:   res = {2'b10, 4'hF};
            7'h00:   res = {2'b01, 4'h0};
            default: res = {2'b00, 4'h0};
        endcase
        decode_glyph = res;
    endfunction

    // {a1, a0, cathode}; idle level of every line is 1
    logic [8:0] sync1_q, sync2_q;
    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       snap_idx_q;
    logic [6:0] snap_cath_q;
    logic [3:0] digit0_q, digit1_q;
    logic       valid0_q, valid1_q;
    logic       cap0_q, cap1_q;
    logic       cap0_d, cap1_d;
    logic       frame_done_q, code_error_q, overlap_error_q;

    logic       a0_s, a1_s;
    logic [6:0] cath_s;
    logic       one_low, both_low, idx_s, changed, do_load;
    logic [5:0] dec_res;
    logic       dec_hit, dec_blank;
    logic [3:0] dec_val;

    assign a1_s   = sync2_q[8];
    assign a0_s   = sync2_q[7];
    assign cath_s = sync2_q[6:0];

    assign one_low  = a0_s ^ a1_s;
    assign both_low = ~a0_s & ~a1_s;
    // a0 high while exactly one anode is low means digit 1 is selected
    assign idx_s    = a0_s;
    assign changed  = (idx_s != snap_idx_q) || (cath_s != snap_cath_q);
    assign do_load  = one_low && ((state_q == IDLE) ||
                                  ((state_q != CAPTURE) && changed));
    assign cnt_d    = cnt_q + 8'd1;

    assign dec_res   = decode_glyph(~snap_cath_q);
    assign dec_hit   = dec_res[5];
    assign dec_blank = dec_res[4];
    assign dec_val   = dec_res[3:0];

    // Blank and illegal glyphs still mark their digit as captured
    assign cap0_d = cap0_q | ~snap_idx_q;
    assign cap1_d = cap1_q |  snap_idx_q;

    // Two-flop synchronizer on every display pin
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {a1, a0, cathode};
            sync2_q <= sync1_q;
        end
    end

    // Scan FSM with registered digit, valid, frame and error outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            snap_idx_q      <= 1'b0;
            snap_cath_q     <= '1;
            digit0_q        <= 4'h0;
            digit1_q        <= 4'h0;
            valid0_q        <= 1'b0;
            valid1_q        <= 1'b0;
            cap0_q          <= 1'b0;
            cap1_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            code_error_q    <= 1'b0;
            overlap_error_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (both_low) begin
                // Ghosted scan: drop any half-settled snapshot
                overlap_error_q <= 1'b1;
                state_q         <= IDLE;
                cnt_q           <= 8'd0;
                snap_cath_q     <= '1;
            end else if (!one_low && (state_q != CAPTURE)) begin
                state_q <= IDLE;
                cnt_q   <= 8'd0;
            end else if (do_load) begin
                snap_idx_q  <= idx_s;
                snap_cath_q <= cath_s;
                cnt_q       <= 8'd1;
                state_q     <= (SETTLE_LIM == 8'd1) ? CAPTURE : SETTLE;
            end else begin
                case (state_q)
                    SETTLE: begin
                        cnt_q <= cnt_d;
                        if (cnt_d == SETTLE_LIM) begin
                            state_q <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (snap_idx_q == 1'b0) begin
                            if (dec_hit) begin
                                digit0_q <= dec_val;
                            end
                            valid0_q <= dec_hit;
                        end else begin
                            if (dec_hit) begin
                                digit1_q <= dec_val;
                            end
                            valid1_q <= dec_hit;
                        end
                        if (!dec_hit && !dec_blank) begin
                            code_error_q <= 1'b1;
                        end
                        if (cap0_d && cap1_d) begin
                            frame_done_q <= 1'b1;
                            cap0_q       <= 1'b0;
                            cap1_q       <= 1'b0;
                        end else begin
                            cap0_q <= cap0_d;
                            cap1_q <= cap1_d;
                        end
                        cnt_q   <= 8'd0;
                        state_q <= HOLD;
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign digit0        = digit0_q;
    assign digit1        = digit1_q;
    assign valid0        = valid0_q;
    assign valid1        = valid1_q;
    assign frame_done    = frame_done_q;
    assign code_error    = code_error_q;
    assign overlap_error = overlap_error_q;

endmodule

// File: doc/segment_scan_decoder.md
SEGMENT_SCAN_DECODER -- requirements
Module: segment_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, the number of consecutive stable synchronized cycles required before a digit is captured (legal range 1-255).
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port a0, input, 1 bit: digit-0 anode select, active-low.
REQ-005 The block SHALL have port a1, input, 1 bit: digit-1 anode select, active-low.
REQ-006 The block SHALL have port cathode, input, 7 bits: segment lines, active-low; cathode[6]=a down to cathode[0]=g.
REQ-007 The block SHALL have ports digit0 and digit1, output, 4 bits each: the last decoded hex value per digit.
REQ-008 The block SHALL have ports valid0 and valid1, output, 1 bit each: the corresponding digit register holds a legal glyph.
REQ-009 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when both digits have been captured since the previous pulse.
REQ-010 The block SHALL have port code_error, output, 1 bit: sticky flag for an unrecognized non-blank glyph.
REQ-011 The block SHALL have port overlap_error, output, 1 bit: sticky flag for both anodes asserted at once.

Function
REQ-012 The block SHALL pass a0, a1 and cathode through a two-flop synchronizer; all subsequent logic SHALL use only the synchronized values.
REQ-013 The block SHALL implement four states: IDLE (no anode active), SETTLE (exactly one anode active, counting), CAPTURE (one cycle), HOLD (waiting for an anode or cathode change).
REQ-014 From IDLE, when exactly one synchronized anode is low, the block SHALL go to SETTLE with the counter at 1, recording the active anode and cathode snapshot.
REQ-015 In SETTLE, the counter SHALL increment each cycle that the anode and cathode equal the snapshot; on reaching SETTLE_CYCLES, the block SHALL go to CAPTURE.
REQ-016 In SETTLE, a changed cathode or a different single anode SHALL reload the snapshot and reset the counter to 1; no active anode SHALL return the block to IDLE.
REQ-017 In CAPTURE, the snapshot SHALL be inverted to active-high abcdefg and decoded as 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
REQ-018 On a match, the block SHALL write digitN and set validN=1 in the cycle after CAPTURE, where N is the recorded anode.
REQ-019 For pattern 00 (blank), the block SHALL hold digitN, clear validN, and raise no error.
REQ-020 For any other pattern, the block SHALL hold digitN, clear validN, and set code_error.
REQ-021 After CAPTURE, the block SHALL enter HOLD; it SHALL leave HOLD for SETTLE on an anode change to the other single anode or a cathode change, and for IDLE when no anode is active.
REQ-022 A blank or illegal capture SHALL still count as a capture of that digit for frame tracking.
REQ-023 The block SHALL keep capture flags cap0 and cap1; when both are set, it SHALL pulse frame_done for exactly one cycle and clear both flags in that same cycle.
REQ-024 Capturing the same digit twice SHALL NOT pulse frame_done.
REQ-025 When both synchronized anodes are low in any state, the block SHALL set overlap_error, go to IDLE, discard the snapshot and counter, and perform no capture.
REQ-026 The sticky flags SHALL clear only on reset.
REQ-027 Latency from the pins to the digit update SHALL be 2 synchronizer cycles + SETTLE_CYCLES + 1 cycle.

Reset
REQ-028 Reset assertion SHALL immediately force state IDLE, counter 0, synchronizer flops to 1 (inactive), digit0=digit1=0, valid0=valid1=0, frame_done=0, code_error=0, overlap_error=0, and cap0=cap1=0.
REQ-029 Reset asserted mid-SETTLE or mid-CAPTURE SHALL abort the capture with no output update.
REQ-030 After deassertion, the block SHALL begin detection on the first following rising edge.

Verification
REQ-031 Bench SHALL drive a0=0, a1=1, cathode=~7'h6D held for 10 cycles, with SETTLE_CYCLES=4 -> digit0=2 and valid0=1 exactly 7 cycles after the pin change; frame_done=0.
REQ-032 Bench SHALL then drive a0=1, a1=0, cathode=~7'h47 -> digit1=F, valid1=1, and frame_done high for exactly 1 cycle in the same cycle valid1 rises.
REQ-033 Bench SHALL drive a0=0, a1=1 with cathode toggling between ~7'h30 and ~7'h79 every 3 cycles -> no capture; digit0 and valid0 unchanged.
REQ-034 Bench SHALL drive a0=0, a1=1, cathode=~7'h01 held -> code_error=1, valid0=0, digit0 unchanged; code_error stays 1 until reset.
REQ-035 Bench SHALL drive a0=0, a1=0 for 1 synchronized cycle during SETTLE -> overlap_error=1, state IDLE, no digit update.
REQ-036 Bench SHALL assert reset 2 cycles into SETTLE -> all outputs 0 immediately; after release, an identical stable pattern captures normally.
